// File: rtl/gb_capture_ctrl_pkg.sv
// Shared definitions for the Game Boy LCD capture controller.
//   cap_state_t  : capture FSM states
//   H_PIX_DEF    : default captured pixels per line
//   V_LINES_DEF  : default captured lines per frame
//   FB_ADDR_W    : framebuffer address width
package gb_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    CAPTURE,
    HOLD
  } cap_state_t;

  localparam int unsigned H_PIX_DEF   = 160;
  localparam int unsigned V_LINES_DEF = 144;
  localparam int unsigned FB_ADDR_W   = 15;

endpackage

// File: rtl/gb_capture_ctrl_sync_edge.sv
// sync_edge: multi-flop synchronizer for an asynchronous input bus, with a
// rising-edge pulse derived from bit 0 of the synchronized value.
//   clk, rst : clock, synchronous active-high reset
//   d        : asynchronous input (W bits)
//   q        : synchronized value after STAGES flops
//   rise     : one-cycle pulse when q[0] goes 0 -> 1
module sync_edge #(
  parameter int unsigned W      = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         rise
);

  logic [W-1:0] sr [STAGES];
  logic         q0_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) sr[i] <= '0;
      q0_d <= 1'b0;
    end else begin
      sr[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
      q0_d <= sr[STAGES-1][0];
    end
  end

  assign q    = sr[STAGES-1];
  assign rise = sr[STAGES-1][0] & ~q0_d;

endmodule

// File: rtl/gb_capture_ctrl.sv
// gb_capture_ctrl: captures the Game Boy LCD pixel stream into a framebuffer.
//   clk, rst          : system clock, synchronous active-high reset
//   di, clki          : async LCD pixel data / pixel clock
//   hsynci, vsynci    : async LCD line / frame sync
//   vga_vsync         : display vsync (clk domain), used for bank swapping
//   wr_en/addr/data   : registered framebuffer write port
//   wr_bank, rd_bank  : capture / display bank select
//   frame_done        : one-cycle pulse with the final pixel write of a frame
//   sync_err          : sticky malformed-timing flag, cleared only by rst
// Build option: DOUBLE_BUFFER_EN enables bank swapping on vga_vsync;
// otherwise both bank selects are tied to 0.
module gb_capture_ctrl
  import gb_capture_ctrl_pkg::*;
#(
  parameter int unsigned H_PIX       = H_PIX_DEF,
  parameter int unsigned V_LINES     = V_LINES_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           di,
  input  logic                 clki,
  input  logic                 hsynci,
  input  logic                 vsynci,
  input  logic                 vga_vsync,
  output logic                 wr_en,
  output logic [FB_ADDR_W-1:0] wr_addr,
  output logic [1:0]           wr_data,
  output logic                 wr_bank,
  output logic                 rd_bank,
  output logic                 frame_done,
  output logic                 sync_err
);

  localparam int unsigned X_W = $clog2(H_PIX + 1);
  localparam int unsigned Y_W = $clog2(V_LINES + 1);

  logic [1:0] di_s;
  logic       ck_rise, hs_rise, vs_rise;
  logic       di_rise_unused, ck_lvl_unused, hs_lvl_unused, vs_lvl_unused;

  sync_edge #(.W(2), .STAGES(SYNC_STAGES)) u_sync_di (
    .clk(clk), .rst(rst), .d(di), .q(di_s), .rise(di_rise_unused));
  sync_edge #(.W(1), .STAGES(SYNC_STAGES)) u_sync_ck (
    .clk(clk), .rst(rst), .d(clki), .q(ck_lvl_unused), .rise(ck_rise));
  sync_edge #(.W(1), .STAGES(SYNC_STAGES)) u_sync_hs (
    .clk(clk), .rst(rst), .d(hsynci), .q(hs_lvl_unused), .rise(hs_rise));
  sync_edge #(.W(1), .STAGES(SYNC_STAGES)) u_sync_vs (
    .clk(clk), .rst(rst), .d(vsynci), .q(vs_lvl_unused), .rise(vs_rise));

  cap_state_t           state, state_n, cstate;
  logic [X_W-1:0]       x, x_n, cx;
  logic [Y_W-1:0]       y, y_n, cy;
  logic [FB_ADDR_W-1:0] base, base_n, cbase;
  logic                 wr_en_n, fd_n, err_n;
  logic [FB_ADDR_W-1:0] wr_addr_n;
  logic [1:0]           wr_data_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_FRAME;
      x          <= '0;
      y          <= '0;
      base       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      base       <= base_n;
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      frame_done <= fd_n;
      sync_err   <= err_n;
    end
  end

  // vsync is applied first to a working copy (cstate/cx/cy/cbase), and the
  // pixel/line handling then runs on that copy, so a coincident vsync and
  // clki rise restarts the frame and writes pixel (0,0) in one step.
  always_comb begin
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    fd_n      = 1'b0;
    err_n     = sync_err;
    cstate    = state;
    cx        = x;
    cy        = y;
    cbase     = base;

    if (vs_rise) begin
      if (state == CAPTURE) err_n = 1'b1;
      cstate = CAPTURE;
      cx     = '0;
      cy     = '0;
      cbase  = '0;
    end

    state_n = cstate;
    x_n     = cx;
    y_n     = cy;
    base_n  = cbase;

    if (cstate == CAPTURE) begin
      if (ck_rise) begin
        if (cx < X_W'(H_PIX) && cy < Y_W'(V_LINES)) begin
          wr_en_n   = 1'b1;
          wr_addr_n = cbase + FB_ADDR_W'(cx);
          wr_data_n = di_s;
          x_n       = cx + 1'b1;
          if (cx == X_W'(H_PIX - 1) && cy == Y_W'(V_LINES - 1)) begin
            fd_n    = 1'b1;
            state_n = HOLD;
          end
        end else begin
          err_n = 1'b1;
        end
      end
      // An hsync at x==0 marks no completed line (e.g. the one that comes
      // with vsync), so it does not advance y.
      if (hs_rise && cx != '0 && cy < Y_W'(V_LINES)) begin
        x_n    = '0;
        y_n    = cy + 1'b1;
        base_n = cbase + FB_ADDR_W'(H_PIX);
      end
    end
  end

`ifdef DOUBLE_BUFFER_EN
  logic vga_d, vga_rise, swap_req;

  assign vga_rise = vga_vsync & ~vga_d;

  // The registered frame_done counts as pending so that a vga_vsync rise in
  // the same cycle swaps immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_d    <= 1'b0;
      swap_req <= 1'b0;
      wr_bank  <= 1'b1;
      rd_bank  <= 1'b0;
    end else begin
      vga_d <= vga_vsync;
      if (vga_rise && (swap_req || frame_done)) begin
        rd_bank  <= wr_bank;
        wr_bank  <= ~wr_bank;
        swap_req <= 1'b0;
      end else if (frame_done) begin
        swap_req <= 1'b1;
      end
    end
  end
`else
  logic vga_vsync_unused;

  assign vga_vsync_unused = vga_vsync;
  assign wr_bank          = 1'b0;
  assign rd_bank          = 1'b0;
`endif

endmodule

// File: tb/tb_gb_capture_ctrl.sv
module tb_gb_capture_ctrl;

  localparam int H   = 16;
  localparam int V   = 12;
  localparam int TOT = H * V;
`ifdef DOUBLE_BUFFER_EN
  localparam logic WB_RST = 1'b1;
`else
  localparam logic WB_RST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  di = '0;
  logic        clki = 1'b0, hsynci = 1'b0, vsynci = 1'b0, vga_vsync = 1'b0;
  logic        wr_en, wr_bank, rd_bank, frame_done, sync_err;
  logic [14:0] wr_addr;
  logic [1:0]  wr_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [14:0] wa_q[$];
  logic [1:0]  wd_q[$];
  int          fd_cnt = 0;
  logic [14:0] fd_addr = '0;
  logic        fd_wen = 1'b0;

  gb_capture_ctrl #(.H_PIX(H), .V_LINES(V), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .di(di), .clki(clki), .hsynci(hsynci),
    .vsynci(vsynci), .vga_vsync(vga_vsync), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_bank(wr_bank),
    .rd_bank(rd_bank), .frame_done(frame_done), .sync_err(sync_err));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_addr = wr_addr;
      fd_wen  = wr_en;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    fd_cnt = 0;
  endtask

  task automatic pix(input logic [1:0] d);
    di = d; clki = 1'b1; tick(4);
    clki = 1'b0; tick(4);
  endtask

  task automatic hs_pulse();
    hsynci = 1'b1; tick(4);
    hsynci = 1'b0; tick(4);
  endtask

  task automatic vs_pulse();
    vsynci = 1'b1; tick(4);
    vsynci = 1'b0; tick(4);
  endtask

  task automatic apply_reset();
    rst = 1'b1; tick(3);
    rst = 1'b0; tick(1);
  endtask

  // vsync, then npix pixels in raster order with an hsync before each line
  task automatic run_frame(input int npix);
    vs_pulse();
    for (int p = 0; p < npix; p++) begin
      if (p % H == 0) hs_pulse();
      pix(2'(p % H));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(3);
    n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
    n_checks++; if (wr_addr !== 15'd0) begin n_errors++; $display("FAIL rst_wr_addr got=%0d exp=0", wr_addr); end
    n_checks++; if (wr_data !== 2'd0) begin n_errors++; $display("FAIL rst_wr_data got=%0d exp=0", wr_data); end
    n_checks++; if (frame_done !== 1'b0) begin n_errors++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
    n_checks++; if (sync_err !== 1'b0) begin n_errors++; $display("FAIL rst_sync_err got=%b exp=0", sync_err); end
    n_checks++; if (wr_bank !== WB_RST) begin n_errors++; $display("FAIL rst_wr_bank got=%b exp=%b", wr_bank, WB_RST); end
    n_checks++; if (rd_bank !== 1'b0) begin n_errors++; $display("FAIL rst_rd_bank got=%b exp=0", rd_bank); end
    rst = 1'b0; tick(1);
    clear_log();
    hs_pulse(); pix(2'd1); pix(2'd2); hs_pulse(); pix(2'd3);
    n_checks++; if (wa_q.size() !== 0) begin n_errors++; $display("FAIL wait_frame_writes got=%0d exp=0", wa_q.size()); end
  endtask

  task automatic test_full_frame();
    apply_reset(); clear_log();
    run_frame(TOT);
    n_checks++; if (wa_q.size() !== TOT) begin n_errors++; $display("FAIL frame_count got=%0d exp=%0d", wa_q.size(), TOT); end
    for (int i = 0; i < TOT && i < wa_q.size(); i++) begin
      n_checks++; if (wa_q[i] !== 15'(i)) begin n_errors++; $display("FAIL frame_addr[%0d] got=%0d exp=%0d", i, wa_q[i], i); end
      n_checks++; if (wd_q[i] !== 2'(i % H)) begin n_errors++; $display("FAIL frame_data[%0d] got=%0d exp=%0d", i, wd_q[i], i % H); end
    end
    n_checks++; if (fd_cnt !== 1) begin n_errors++; $display("FAIL frame_done_count got=%0d exp=1", fd_cnt); end
    n_checks++; if (fd_wen !== 1'b1) begin n_errors++; $display("FAIL frame_done_with_wr_en got=%b exp=1", fd_wen); end
    n_checks++; if (fd_addr !== 15'(TOT - 1)) begin n_errors++; $display("FAIL frame_done_addr got=%0d exp=%0d", fd_addr, TOT - 1); end
    n_checks++; if (sync_err !== 1'b0) begin n_errors++; $display("FAIL frame_sync_err got=%b exp=0", sync_err); end
    clear_log();
    hs_pulse(); pix(2'd3); pix(2'd1);
    n_checks++; if (wa_q.size() !== 0) begin n_errors++; $display("FAIL hold_writes got=%0d exp=0", wa_q.size()); end
    n_checks++; if (wr_addr !== 15'(TOT - 1)) begin n_errors++; $display("FAIL hold_addr got=%0d exp=%0d", wr_addr, TOT - 1); end
  endtask

  task automatic test_latency();
    apply_reset(); vs_pulse(); clear_log();
    di = 2'd2; clki = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      n_checks++;
      if (wr_en !== (e == 3)) begin n_errors++; $display("FAIL latency_edge%0d wr_en got=%b exp=%b", e, wr_en, (e == 3)); end
      if (e == 3) begin
        n_checks++; if (wr_addr !== 15'd0) begin n_errors++; $display("FAIL latency_addr got=%0d exp=0", wr_addr); end
        n_checks++; if (wr_data !== 2'd2) begin n_errors++; $display("FAIL latency_data got=%0d exp=2", wr_data); end
      end
    end
    #1; clki = 1'b0; tick(4);
  endtask

  task automatic test_overrun();
    apply_reset(); vs_pulse(); clear_log();
    for (int i = 0; i < H; i++) pix(2'(i));
    n_checks++; if (sync_err !== 1'b0) begin n_errors++; $display("FAIL overrun_err_before got=%b exp=0", sync_err); end
    pix(2'd3);
    n_checks++; if (wa_q.size() !== H) begin n_errors++; $display("FAIL overrun_count got=%0d exp=%0d", wa_q.size(), H); end
    n_checks++; if (wa_q.size() == H && wa_q[H-1] !== 15'(H - 1)) begin n_errors++; $display("FAIL overrun_last_addr got=%0d exp=%0d", wa_q[H-1], H - 1); end
    n_checks++; if (sync_err !== 1'b1) begin n_errors++; $display("FAIL overrun_err got=%b exp=1", sync_err); end
  endtask

  task automatic test_early_vsync();
    apply_reset(); clear_log();
    run_frame(5 * H);
    n_checks++; if (sync_err !== 1'b0) begin n_errors++; $display("FAIL early_err_before got=%b exp=0", sync_err); end
    clear_log();
    vs_pulse();
    n_checks++; if (sync_err !== 1'b1) begin n_errors++; $display("FAIL early_err got=%b exp=1", sync_err); end
    pix(2'd1);
    n_checks++; if (fd_cnt !== 0) begin n_errors++; $display("FAIL early_frame_done got=%0d exp=0", fd_cnt); end
    n_checks++; if (wa_q.size() !== 1 || wa_q[0] !== 15'd0) begin n_errors++; $display("FAIL early_restart_addr got_n=%0d exp addr 0", wa_q.size()); end
    n_checks++; if (rd_bank !== 1'b0 || wr_bank !== WB_RST) begin n_errors++; $display("FAIL early_no_swap got=%b%b exp=%b0", wr_bank, rd_bank, WB_RST); end
    hs_pulse(); pix(2'd0);
    n_checks++; if (sync_err !== 1'b1) begin n_errors++; $display("FAIL early_err_sticky got=%b exp=1", sync_err); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    run_frame(H);
    vs_pulse();
    run_frame(3 * H + 5);
    hs_pulse(); pix(2'd1);
    rst = 1'b1; tick(2);
    n_checks++; if (wr_en !== 1'b0 || wr_addr !== 15'd0 || wr_data !== 2'd0) begin n_errors++; $display("FAIL midrst_wr got=%b/%0d/%0d exp=0/0/0", wr_en, wr_addr, wr_data); end
    n_checks++; if (frame_done !== 1'b0 || sync_err !== 1'b0) begin n_errors++; $display("FAIL midrst_flags got=%b/%b exp=0/0", frame_done, sync_err); end
    n_checks++; if (wr_bank !== WB_RST || rd_bank !== 1'b0) begin n_errors++; $display("FAIL midrst_banks got=%b%b exp=%b0", wr_bank, rd_bank, WB_RST); end
    rst = 1'b0; tick(1); clear_log();
    pix(2'd1); pix(2'd2); hs_pulse(); pix(2'd3);
    n_checks++; if (wa_q.size() !== 0) begin n_errors++; $display("FAIL midrst_ignored got=%0d exp=0", wa_q.size()); end
    vs_pulse(); pix(2'd2);
    n_checks++; if (wa_q.size() !== 1 || wa_q[0] !== 15'd0 || wd_q[0] !== 2'd2) begin n_errors++; $display("FAIL midrst_resume got_n=%0d exp one write addr 0 data 2", wa_q.size()); end
  endtask

  task automatic test_simultaneous();
    apply_reset(); clear_log();
    di = 2'd3; vsynci = 1'b1; clki = 1'b1; hsynci = 1'b1; tick(4);
    vsynci = 1'b0; clki = 1'b0; hsynci = 1'b0; tick(4);
    n_checks++; if (wa_q.size() !== 1 || wa_q[0] !== 15'd0 || wd_q[0] !== 2'd3) begin n_errors++; $display("FAIL simul_first got_n=%0d exp one write addr 0 data 3", wa_q.size()); end
    pix(2'd1);
    n_checks++; if (wa_q.size() !== 2 || wa_q[1] !== 15'd1) begin n_errors++; $display("FAIL simul_second got_n=%0d exp addr 1", wa_q.size()); end
    n_checks++; if (sync_err !== 1'b0) begin n_errors++; $display("FAIL simul_err got=%b exp=0", sync_err); end
  endtask

  task automatic test_banks();
    apply_reset(); clear_log();
    run_frame(TOT);
`ifdef DOUBLE_BUFFER_EN
    n_checks++; if (wr_bank !== 1'b1 || rd_bank !== 1'b0) begin n_errors++; $display("FAIL bank_pending got=%b%b exp=10", wr_bank, rd_bank); end
    tick(100);
    vga_vsync = 1'b1; tick(1); vga_vsync = 1'b0; tick(2);
    n_checks++; if (wr_bank !== 1'b0 || rd_bank !== 1'b1) begin n_errors++; $display("FAIL bank_swap1 got=%b%b exp=01", wr_bank, rd_bank); end
    // second frame: vga_vsync rise lands in the frame_done cycle
    run_frame(TOT - 1);
    di = 2'(H - 1); clki = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (frame_done !== 1'b1) begin n_errors++; $display("FAIL bank_fd_timing got=%b exp=1", frame_done); end
    #1; vga_vsync = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (wr_bank !== 1'b1 || rd_bank !== 1'b0) begin n_errors++; $display("FAIL bank_swap_coincident got=%b%b exp=10", wr_bank, rd_bank); end
    #1; vga_vsync = 1'b0; clki = 1'b0; tick(4);
    vga_vsync = 1'b1; tick(1); vga_vsync = 1'b0; tick(2);
    n_checks++; if (wr_bank !== 1'b1 || rd_bank !== 1'b0) begin n_errors++; $display("FAIL bank_no_extra_swap got=%b%b exp=10", wr_bank, rd_bank); end
`else
    tick(100);
    vga_vsync = 1'b1; tick(1); vga_vsync = 1'b0; tick(2);
    n_checks++; if (fd_cnt !== 1) begin n_errors++; $display("FAIL bank_fd got=%0d exp=1", fd_cnt); end
    n_checks++; if (wr_bank !== 1'b0 || rd_bank !== 1'b0) begin n_errors++; $display("FAIL bank_const got=%b%b exp=00", wr_bank, rd_bank); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_latency();
    test_overrun();
    test_early_vsync();
    test_mid_reset();
    test_simultaneous();
    test_banks();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
